// File: rtl/mod_exp_pkg.sv
// Shared sizing and FSM state codes for the modular exponentiation core.
// Build option MOD_EXP_RES_ZERO_EN (see mod_exp_core) changes only the res_out hold behaviour.
package mod_exp_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int NUM_WORDS  = 64;

   typedef enum logic [4:0] {
      INIT_STATE       = 5'd0,
      LOAD_M_E         = 5'd1,
      LOAD_N           = 5'd2,
      WAIT_COMPUTE     = 5'd3,
      CALC_M_BAR       = 5'd4,
      GET_K_E          = 5'd5,
      BIGLOOP          = 5'd6,
      CALC_C_BAR_M_BAR = 5'd7,
      CALC_C_BAR_1     = 5'd8,
      COMPLETE         = 5'd9,
      OUTPUT_RESULT    = 5'd10,
      TERMINAL         = 5'd11
   } exp_state_t;

   typedef enum logic [3:0] {
      MM_IDLE  = 4'd0,
      MM_MUL   = 4'd1,
      MM_RED   = 4'd2,
      MM_SHIFT = 4'd3,
      MM_SUB   = 4'd4,
      MM_DONE  = 4'd5
   } mm_state_t;

endpackage

// File: rtl/mont_mul.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*2^-(DATA_WIDTH*NUM_WORDS) mod n,
// fully reduced below n, one DATA_WIDTH x DATA_WIDTH multiply-accumulate per cycle.
//
// state    | meaning
// MM_IDLE  | waiting for start
// MM_MUL   | t += a * b[i], one word of a per cycle
// MM_RED   | t += m * n, dropping the zero low word
// MM_SHIFT | fold the reduction carry into the top words, advance i
// MM_SUB   | word-serial t - n trial subtraction
// MM_DONE  | pick t or t - n, pulse done
module mont_mul #(
   parameter int DATA_WIDTH = mod_exp_pkg::DATA_WIDTH,
   parameter int NUM_WORDS  = mod_exp_pkg::NUM_WORDS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0]   a,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0]   b,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0]   n,
   input  logic [DATA_WIDTH-1:0]             nprime,
   output logic [DATA_WIDTH*NUM_WORDS-1:0]   result,
   output logic                              done,
   output logic [3:0]                        state
);
   import mod_exp_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int NW = NUM_WORDS;
   localparam int CW = $clog2(NW + 2);
   localparam logic [CW-1:0] LAST = CW'(NW - 1);

   mm_state_t       mm_st;
   logic [DW-1:0]   t [NW+2];
   logic [DW-1:0]   d [NW];
   logic [CW-1:0]   i, j, jm1;
   logic [DW-1:0]   carry, m_reg;
   logic            borrow, use_diff;

   logic [DW-1:0]   a_w, b_w, n_w, m_comb, m_cur;
   logic [2*DW-1:0] mul_sum, red_sum, top_sum;
   logic [DW:0]     sh_sum, sub_diff;

   assign a_w    = a[j*DW +: DW];
   assign b_w    = b[i*DW +: DW];
   assign n_w    = n[j*DW +: DW];
   assign jm1    = j - 1'b1;
   assign m_comb = t[0] * nprime;
   assign m_cur  = (j == '0) ? m_comb : m_reg;

   assign mul_sum  = (2*DW)'(t[j]) + (2*DW)'(a_w) * (2*DW)'(b_w) + (2*DW)'(carry);
   assign top_sum  = (2*DW)'(t[NW]) + (2*DW)'(mul_sum[2*DW-1:DW]);
   assign red_sum  = (2*DW)'(t[j]) + (2*DW)'(m_cur) * (2*DW)'(n_w) + (2*DW)'(carry);
   assign sh_sum   = (DW+1)'(t[NW]) + (DW+1)'(carry);
   assign sub_diff = (DW+1)'(t[j]) - (DW+1)'(n_w) - (DW+1)'(borrow);
   // t < 2n here, so t >= n exactly when the overflow word is set or the subtraction did not borrow
   assign use_diff = (t[NW] != '0) || !borrow;

   assign state = mm_st;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mm_st  <= MM_IDLE;
         i      <= '0;
         j      <= '0;
         carry  <= '0;
         m_reg  <= '0;
         borrow <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         for (int k = 0; k < NW + 2; k++) t[k] <= '0;
         for (int k = 0; k < NW; k++)     d[k] <= '0;
      end else begin
         done <= 1'b0;
         case (mm_st)
            MM_IDLE: begin
               if (start) begin
                  for (int k = 0; k < NW + 2; k++) t[k] <= '0;
                  i     <= '0;
                  j     <= '0;
                  carry <= '0;
                  mm_st <= MM_MUL;
               end
            end
            MM_MUL: begin
               t[j] <= mul_sum[DW-1:0];
               if (j == LAST) begin
                  t[NW]   <= top_sum[DW-1:0];
                  t[NW+1] <= top_sum[2*DW-1:DW];
                  carry   <= '0;
                  j       <= '0;
                  mm_st   <= MM_RED;
               end else begin
                  carry <= mul_sum[2*DW-1:DW];
                  j     <= j + 1'b1;
               end
            end
            MM_RED: begin
               if (j == '0) m_reg <= m_comb;
               else         t[jm1] <= red_sum[DW-1:0];
               carry <= red_sum[2*DW-1:DW];
               if (j == LAST) mm_st <= MM_SHIFT;
               else           j <= j + 1'b1;
            end
            MM_SHIFT: begin
               t[NW-1] <= sh_sum[DW-1:0];
               t[NW]   <= t[NW+1] + DW'(sh_sum[DW]);
               t[NW+1] <= '0;
               carry   <= '0;
               borrow  <= 1'b0;
               j       <= '0;
               if (i == LAST) mm_st <= MM_SUB;
               else begin
                  i     <= i + 1'b1;
                  mm_st <= MM_MUL;
               end
            end
            MM_SUB: begin
               d[j]   <= sub_diff[DW-1:0];
               borrow <= sub_diff[DW];
               if (j == LAST) mm_st <= MM_DONE;
               else           j <= j + 1'b1;
            end
            MM_DONE: begin
               for (int k = 0; k < NW; k++)
                  result[k*DW +: DW] <= use_diff ? d[k] : t[k];
               done  <= 1'b1;
               mm_st <= MM_IDLE;
            end
            default: mm_st <= MM_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mod_exp_core.sv
// Montgomery modular exponentiation c = m^e mod n: word-serial operand load, left-to-right
// square-and-multiply over mont_mul, word-serial readout. MOD_EXP_RES_ZERO_EN zeroes res_out outside readout.
//
// state            | meaning
// INIT_STATE       | idle after reset
// LOAD_M_E         | shift in one word of m, e, n, R mod n, R^2 mod n per edge
// LOAD_N           | reserved, never entered
// WAIT_COMPUTE     | operands loaded, waiting for startCompute
// CALC_M_BAR       | m_bar = MM(m, R^2)
// GET_K_E          | scan down for the top set exponent bit
// BIGLOOP          | c_bar = MM(c_bar, c_bar) for bit k
// CALC_C_BAR_M_BAR | c_bar = MM(c_bar, m_bar) when bit k is set
// CALC_C_BAR_1     | c = MM(c_bar, 1), leave Montgomery domain
// COMPLETE         | result ready, waiting for getResult
// OUTPUT_RESULT    | one result word per edge, LSW first
// TERMINAL         | readout finished
module mod_exp_core #(
   parameter int DATA_WIDTH = mod_exp_pkg::DATA_WIDTH,
   parameter int NUM_WORDS  = mod_exp_pkg::NUM_WORDS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] m_buf,
   input  logic [DATA_WIDTH-1:0] e_buf,
   input  logic [DATA_WIDTH-1:0] n_buf,
   input  logic [DATA_WIDTH-1:0] r_buf,
   input  logic [DATA_WIDTH-1:0] t_buf,
   input  logic [DATA_WIDTH-1:0] nprime0,
   input  logic                  startInput,
   input  logic                  startCompute,
   input  logic                  getResult,
   output logic [4:0]            exp_state,
   output logic [3:0]            state,
   output logic [DATA_WIDTH-1:0] res_out
);
   import mod_exp_pkg::*;

   localparam int DW  = DATA_WIDTH;
   localparam int NW  = NUM_WORDS;
   localparam int W   = DW * NW;
   localparam int KW  = $clog2(W);
   localparam int CTW = $clog2(NW + 1);
   localparam logic [KW-1:0]  K_TOP    = KW'(W - 1);
   localparam logic [CTW-1:0] CNT_LAST = CTW'(NW - 1);

   exp_state_t     exp_st;
   logic [W-1:0]   m_reg, e_reg, n_reg, r_reg, t_reg;
   logic [W-1:0]   m_bar, c_bar;
   logic [DW-1:0]  np_reg;
   logic [KW-1:0]  k;
   logic [CTW-1:0] cnt;
   logic           mm_start, mm_done;
   logic [W-1:0]   mm_a, mm_b, mm_res;

   assign exp_state = exp_st;

   always_comb begin
      mm_a = c_bar;
      mm_b = c_bar;
      case (exp_st)
         CALC_M_BAR: begin
            mm_a = m_reg;
            mm_b = t_reg;
         end
         CALC_C_BAR_M_BAR: mm_b = m_bar;
         CALC_C_BAR_1:     mm_b = W'(1);
         default: ;
      endcase
   end

   mont_mul #(
      .DATA_WIDTH (DW),
      .NUM_WORDS  (NW)
   ) u_mont_mul (
      .clk    (clk),
      .reset  (reset),
      .start  (mm_start),
      .a      (mm_a),
      .b      (mm_b),
      .n      (n_reg),
      .nprime (np_reg),
      .result (mm_res),
      .done   (mm_done),
      .state  (state)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_st   <= INIT_STATE;
         m_reg    <= '0;
         e_reg    <= '0;
         n_reg    <= '0;
         r_reg    <= '0;
         t_reg    <= '0;
         m_bar    <= '0;
         c_bar    <= '0;
         np_reg   <= '0;
         k        <= '0;
         cnt      <= '0;
         mm_start <= 1'b0;
         res_out  <= '0;
      end else begin
         mm_start <= 1'b0;
`ifdef MOD_EXP_RES_ZERO_EN
         if (exp_st != OUTPUT_RESULT) res_out <= '0;
`endif
         case (exp_st)
            INIT_STATE, TERMINAL: begin
               if (startInput) begin
                  cnt    <= CNT_LAST;
                  exp_st <= LOAD_M_E;
               end
            end
            LOAD_M_E: begin
               m_reg <= {m_buf, m_reg[W-1:DW]};
               e_reg <= {e_buf, e_reg[W-1:DW]};
               n_reg <= {n_buf, n_reg[W-1:DW]};
               r_reg <= {r_buf, r_reg[W-1:DW]};
               t_reg <= {t_buf, t_reg[W-1:DW]};
               if (cnt == '0) exp_st <= WAIT_COMPUTE;
               else           cnt <= cnt - 1'b1;
            end
            WAIT_COMPUTE: begin
               if (startCompute) begin
                  np_reg   <= nprime0;
                  c_bar    <= r_reg;
                  mm_start <= 1'b1;
                  exp_st   <= CALC_M_BAR;
               end
            end
            CALC_M_BAR: begin
               if (mm_done) begin
                  m_bar  <= mm_res;
                  k      <= K_TOP;
                  exp_st <= GET_K_E;
               end
            end
            GET_K_E: begin
               if (e_reg[k]) begin
                  mm_start <= 1'b1;
                  exp_st   <= BIGLOOP;
               end else if (k == '0) begin
                  // e = 0: c_bar still holds R mod n, so the exit multiply yields 1
                  mm_start <= 1'b1;
                  exp_st   <= CALC_C_BAR_1;
               end else begin
                  k <= k - 1'b1;
               end
            end
            BIGLOOP: begin
               if (mm_done) begin
                  c_bar    <= mm_res;
                  mm_start <= 1'b1;
                  if (e_reg[k])       exp_st <= CALC_C_BAR_M_BAR;
                  else if (k == '0)   exp_st <= CALC_C_BAR_1;
                  else                k <= k - 1'b1;
               end
            end
            CALC_C_BAR_M_BAR: begin
               if (mm_done) begin
                  c_bar    <= mm_res;
                  mm_start <= 1'b1;
                  if (k == '0) exp_st <= CALC_C_BAR_1;
                  else begin
                     k      <= k - 1'b1;
                     exp_st <= BIGLOOP;
                  end
               end
            end
            CALC_C_BAR_1: begin
               if (mm_done) begin
                  c_bar  <= mm_res;
                  exp_st <= COMPLETE;
               end
            end
            COMPLETE: begin
               if (getResult) begin
                  cnt    <= CNT_LAST;
                  exp_st <= OUTPUT_RESULT;
               end
            end
            OUTPUT_RESULT: begin
               res_out <= c_bar[DW-1:0];
               c_bar   <= c_bar >> DW;
               if (cnt == '0) exp_st <= TERMINAL;
               else           cnt <= cnt - 1'b1;
            end
            default: exp_st <= INIT_STATE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_core.sv
// Self-checking bench for mod_exp_core at a reduced operand size (32-bit words, 8 words).
// Expected results come from plain big-integer modular arithmetic in the bench.
module tb_mod_exp_core;

   localparam int DW = 32;
   localparam int NW = 8;
   localparam int W  = DW * NW;
   localparam int MM_BOUND = 2 * NW * (NW + 2) + NW + 4;
`ifdef MOD_EXP_RES_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
   logic          startInput, startCompute, getResult;
   logic [4:0]    exp_state;
   logic [3:0]    state;
   logic [DW-1:0] res_out;

   int n_checks = 0;
   int n_errors = 0;
   int mm_run   = 0;
   int mm_max   = 0;

   mod_exp_core #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .clk          (clk),
      .reset        (reset),
      .m_buf        (m_buf),
      .e_buf        (e_buf),
      .n_buf        (n_buf),
      .r_buf        (r_buf),
      .t_buf        (t_buf),
      .nprime0      (nprime0),
      .startInput   (startInput),
      .startCompute (startCompute),
      .getResult    (getResult),
      .exp_state    (exp_state),
      .state        (state),
      .res_out      (res_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // longest uninterrupted multiplier activity
   always @(negedge clk) begin
      if (state != 4'd0) mm_run++;
      else mm_run = 0;
      if (mm_run > mm_max) mm_max = mm_run;
   end

   typedef struct {
      logic [W-1:0] m;
      logic [W-1:0] e;
      logic [W-1:0] n;
      logic [W-1:0] c;
      int           hold;
   } vec_t;

   vec_t tbl [7];

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] n);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      p = p % {{W{1'b0}}, n};
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] r_mod(input logic [W-1:0] n);
      logic [2*W-1:0] p;
      p = '0;
      p[W] = 1'b1;
      p = p % {{W{1'b0}}, n};
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
      logic [W-1:0] acc, base;
      acc  = W'(1);
      base = m;
      for (int i = 0; i < W; i++) begin
         if (e[i]) acc = mulmod(acc, base, n);
         base = mulmod(base, base, n);
      end
      return acc;
   endfunction

   function automatic logic [DW-1:0] nprime_of(input logic [W-1:0] n);
      logic [DW-1:0] n0, inv;
      n0  = n[DW-1:0];
      inv = n0;
      for (int i = 0; i < 6; i++) inv = inv * (DW'(2) - n0 * inv);
      return '0 - inv;
   endfunction

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic load_ops(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
      logic [W-1:0] r, t;
      r = r_mod(n);
      t = mulmod(r, r, n);
      @(negedge clk);
      startInput = 1'b1;
      @(negedge clk);
      startInput = 1'b0;
      for (int w = 0; w < NW; w++) begin
         m_buf = m[w*DW +: DW];
         e_buf = e[w*DW +: DW];
         n_buf = n[w*DW +: DW];
         r_buf = r[w*DW +: DW];
         t_buf = t[w*DW +: DW];
         @(negedge clk);
      end
      m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
   endtask

   task automatic start_compute(input logic [W-1:0] n);
      nprime0      = nprime_of(n);
      startCompute = 1'b1;
      @(negedge clk);
      startCompute = 1'b0;
      nprime0      = '0;
   endtask

   task automatic finish_case(input string name, input logic [W-1:0] exp_c, input int hold);
      int cyc;
      logic [W-1:0] got;
      cyc = 0;
      while (exp_state != 5'd9 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      if (exp_state != 5'd9) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: exp_state %0d expected 9 within 20000 cycles", name, exp_state);
         return;
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({name, " hold_complete"}, W'(exp_state), W'(9));
      end
      getResult = 1'b1;
      @(negedge clk);
      getResult = 1'b0;
      got = '0;
      for (int j = 0; j < NW; j++) begin
         @(negedge clk);
         got[j*DW +: DW] = res_out;
      end
      check({name, " result"}, got, exp_c);
      check({name, " terminal_state"}, W'(exp_state), W'(11));
      repeat (2) @(negedge clk);
      check({name, " terminal_res"}, W'(res_out), ZERO_EN ? '0 : W'(exp_c[W-DW +: DW]));
   endtask

   task automatic run_case(input string name, input logic [W-1:0] m, input logic [W-1:0] e,
                           input logic [W-1:0] n, input logic [W-1:0] exp_c, input int hold);
      load_ops(m, e, n);
      check({name, " wait_state"}, W'(exp_state), W'(3));
      start_compute(n);
      finish_case(name, exp_c, hold);
   endtask

   initial begin
      logic [W-1:0] rm, re, rn;
      int cyc;

      tbl[0] = '{m: W'(8),  e: W'(13), n: W'(77), c: W'(50), hold: 5};
      tbl[1] = '{m: W'(50), e: W'(37), n: W'(77), c: W'(8),  hold: 0};
      tbl[2] = '{m: W'(8),  e: W'(0),  n: W'(77), c: W'(1),  hold: 2};
      tbl[3] = '{m: W'(8),  e: W'(1),  n: W'(77), c: W'(8),  hold: 0};
      tbl[4] = '{m: W'(2),  e: W'(10), n: W'(77), c: W'(23), hold: 0};
      tbl[5] = '{m: W'(3),  e: W'(5),  n: W'(7),  c: W'(5),  hold: 0};
      tbl[6] = '{m: W'(76), e: W'(2),  n: W'(77), c: W'(1),  hold: 0};

      reset = 1'b0;
      m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0; nprime0 = '0;
      startInput = 1'b0; startCompute = 1'b0; getResult = 1'b0;
      repeat (3) @(negedge clk);
      check("reset exp_state", W'(exp_state), '0);
      check("reset mm_state", W'(state), '0);
      check("reset res_out", W'(res_out), '0);
      reset = 1'b1;
      @(negedge clk);
      check("idle exp_state", W'(exp_state), '0);

      for (int i = 0; i < 7; i++)
         run_case($sformatf("vec%0d", i), tbl[i].m, tbl[i].e, tbl[i].n, tbl[i].c, tbl[i].hold);

      for (int i = 0; i < 3; i++) begin
         rn = rand_wide();
         rn[W-1] = 1'b1;
         rn[0]   = 1'b1;
         rm = rand_wide() % rn;
         re = (i == 0) ? W'(65537) : W'($urandom_range(24'hffffff, 2));
         run_case($sformatf("rand%0d", i), rm, re, rn, modexp(rm, re, rn), 0);
      end

      // abort mid-exponentiation, then a full reload must give the normal answer
      load_ops(W'(8), W'(13), W'(77));
      start_compute(W'(77));
      cyc = 0;
      while (exp_state != 5'd6 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("reach BIGLOOP", W'(exp_state), W'(6));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort exp_state", W'(exp_state), '0);
      check("abort mm_state", W'(state), '0);
      check("abort res_out", W'(res_out), '0);
      @(negedge clk);
      reset = 1'b1;
      run_case("rerun", W'(8), W'(13), W'(77), W'(50), 0);

      n_checks++;
      if (mm_max == 0 || mm_max > MM_BOUND) begin
         n_errors++;
         $display("FAIL mm_latency: got %0d cycles, required 1..%0d", mm_max, MM_BOUND);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
